wishbone_rr_arbiter: RTL

Round-robin arbiter sharing one Wishbone classic bus among NUM_MASTERS wishbone_master-style initiators. It sits between the initiators and the shared slave interconnect and grants the bus per cycle-group: the owner keeps it while its CYC is high. A watchdog aborts stalled transfers with a one-cycle ERR pulse so a silent slave cannot lock the bus.

---
 rtl/wishbone_rr_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin owner-per-CYC arbiter for a shared Wishbone classic bus. Grant is registered (1 cycle after CYC).
// Masters that are not the owner stall on CYC; a stalled strobe is aborted with a one-cycle ERR after TIMEOUT cycles.
module wishbone_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int TIMEOUT     = 16
) (
    input  logic                             i_CLK,
    input  logic                             i_RSTN,
    input  logic [NUM_MASTERS-1:0]           i_M_CYC,
    input  logic [NUM_MASTERS-1:0]           i_M_STB,
    input  logic [NUM_MASTERS-1:0]           i_M_WE,
    input  logic [4*NUM_MASTERS-1:0]         i_M_SEL,
    input  logic [ADDR_WIDTH*NUM_MASTERS-1:0] i_M_ADDR,
    input  logic [DATA_WIDTH*NUM_MASTERS-1:0] i_M_DATA,
    output logic [NUM_MASTERS-1:0]           o_M_ACK,
    output logic [NUM_MASTERS-1:0]           o_M_ERR,
    output logic [DATA_WIDTH-1:0]            o_M_DATA,
    output logic [NUM_MASTERS-1:0]           o_GNT,
    output logic                             o_CYC,
    output logic                             o_STB,
    output logic                             o_WE,
    output logic [3:0]                       o_SEL,
    output logic [ADDR_WIDTH-1:0]            o_ADDR,
    output logic [DATA_WIDTH-1:0]            o_DATA,
    input  logic [DATA_WIDTH-1:0]            i_DATA,
    input  logic                             i_ACK
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_MASTERS-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [WW-1:0]           wd_q, wd_d;

    logic [IW-1:0]           win_idx;
    logic [IW-1:0]           cand;
    logic                    any_req;

    logic                    own_cyc;
    logic                    own_stb;
    logic                    own_we;
    logic [3:0]              own_sel;
    logic [ADDR_WIDTH-1:0]   own_addr;
    logic [DATA_WIDTH-1:0]   own_dat;

    logic                    bus_own;
    logic                    stall;
    logic                    timeout;

    assign any_req = |i_M_CYC;

    // Scan downward so the last hit is the first requester after the previous owner.
    always_comb begin
        win_idx = ptr_q;
        cand    = ptr_q;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            cand = IW'((int'(ptr_q) + k) % NUM_MASTERS);
            if (i_M_CYC[cand]) begin
                win_idx = cand;
            end
        end
    end

    // ptr_q doubles as the owner index whenever a grant is held.
    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_sel  = '0;
        own_addr = '0;
        own_dat  = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (ptr_q == IW'(m)) begin
                own_cyc  = i_M_CYC[m];
                own_stb  = i_M_STB[m];
                own_we   = i_M_WE[m];
                own_sel  = i_M_SEL[4*m +: 4];
                own_addr = i_M_ADDR[ADDR_WIDTH*m +: ADDR_WIDTH];
                own_dat  = i_M_DATA[DATA_WIDTH*m +: DATA_WIDTH];
            end
        end
    end

    assign bus_own = (state_q == ST_OWN);
    assign stall   = bus_own && own_stb && !i_ACK;
    assign timeout = stall && (wd_q == WW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        wd_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_OWN;
                    ptr_d   = win_idx;
                    gnt_d   = NUM_MASTERS'(1) << win_idx;
                end
            end
            ST_OWN: begin
                if (timeout) begin
                    state_d = ST_ABORT;
                end else if (!own_cyc) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end else if (stall) begin
                    wd_d = wd_q + WW'(1);
                end
            end
            ST_ABORT: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= IW'(NUM_MASTERS - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
        end
    end

    // Everything facing the slave is quiet unless the owner is actively transferring.
    assign o_GNT    = gnt_q;
    assign o_CYC    = bus_own & own_cyc;
    assign o_STB    = bus_own & own_stb;
    assign o_WE     = bus_own & own_we;
    assign o_SEL    = bus_own ? own_sel  : '0;
    assign o_ADDR   = bus_own ? own_addr : '0;
    assign o_DATA   = bus_own ? own_dat  : '0;
    assign o_M_DATA = bus_own ? i_DATA   : '0;
    assign o_M_ACK  = (bus_own && i_ACK) ? gnt_q : '0;
    assign o_M_ERR  = timeout ? gnt_q : '0;

endmodule
